llc_lookup_sched: RTL
=====================

# llc_lookup_sched

Sequencer for the LLC way-lookup datapath. It accepts one set-lookup request at a time and reads the tag/state arrays for that set. It then drives the way-lookup stage with the set's round-robin eviction pointer, presents the chosen way and evict flag downstream over a valid/ready handshake, and advances the per-set eviction pointer when an eviction is consumed. It sits between the request decoder and the LLC process stage.

## Interface
- SETS, 256, number of LLC sets (power of two)
- SET_BITS, 8, log2(SETS)
- WAYS, 16, ways per set (power of two)
- WAY_BITS, 4, log2(WAYS)

- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- req_valid  in  1  lookup request pending
- req_set  in  SET_BITS  set index of request
- req_ready  out  1  request accepted when high with req_valid
- clr  in  1  clear all eviction pointers
- rd_en  out  1  tag/state array read strobe
- rd_set  out  SET_BITS  array read index
- lookup_en  out  1  enables way-lookup stage capture (also pops its input FIFO)
- evict_way_buf  out  WAY_BITS  eviction start pointer for current set
- lk_way  in  WAY_BITS  registered way from lookup stage
- lk_evict  in  1  registered evict flag from lookup stage
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- out_set  out  SET_BITS  set of result
- out_way  out  WAY_BITS  selected way
- out_evict  out  1  selected way requires eviction

## Operation
- FSM states: IDLE, RD, LKUP, RESP. Reset state is IDLE.
- IDLE:
  - req_ready = !clr.
  - clr has priority: all ptr[] <= 0 in one cycle; no request is accepted that cycle.
  - On req_valid && req_ready: set_q <= req_set; go to RD.
  - clr is ignored in every state other than IDLE.
- RD: rd_en=1, rd_set=set_q. Go to LKUP unconditionally.
- LKUP:
  - Array data is valid this cycle (1-cycle array read latency).
  - lookup_en=1, evict_way_buf=ptr[set_q]. Go to RESP.
- RESP:
  - out_valid=1; out_way=lk_way, out_evict=lk_evict, out_set=set_q.
  - Outputs are held stable until out_ready.
  - On out_valid && out_ready:
    - If out_evict, ptr[set_q] <= (out_way + 1) mod WAYS, with WAY_BITS wrap (WAYS-1 -> 0).
    - Go to IDLE.
  - Hits and empty-way fills (out_evict=0) leave ptr unchanged.
- Pointer table: SETS x WAY_BITS flops, async-cleared to 0.
- evict_way_buf equals ptr[set_q] in all states, including the cycle of a pointer update; it is used only in LKUP.
- rd_en, lookup_en and out_valid are each high exactly one state's worth. They are never simultaneously high.
- Only one request is in flight, so there are no same-set hazards.

## Timing
- Reset (rst low), immediately and asynchronously:
  - state=IDLE, set_q=0, all ptr=0.
  - rd_en=0, lookup_en=0, out_valid=0, out_way=0, out_evict=0, out_set=0, rd_set=0, evict_way_buf=0.
  - req_ready = !clr.
- Cycle map for a request accepted at edge of cycle 0:
  - rd_en high in cycle 1.
  - lookup_en high in cycle 2.
  - out_valid high from cycle 3.
- Minimum latency is 3 cycles. Peak throughput is 1 request per 4 cycles: next accept in cycle 4 if out_ready in cycle 3.
- Backpressure: out_valid stays high and all out_* stay stable while out_ready=0. No pointer update occurs until the handshake.
- Pointer update is visible at the clock edge completing the RESP handshake. A following request to the same set sees the new value in its LKUP cycle.
- Reset mid-operation aborts the in-flight request. No pointer update or out_valid is produced for it.

## Test plan
- Reset, then req_set=5, lk_way=3, lk_evict=1, out_ready=1 -> rd_en cycle 1, lookup_en cycle 2 with evict_way_buf=0, out_valid cycle 3 (way 3, evict 1); afterwards ptr[5]=4.
- Same set again with lk_evict=0, lk_way=9 -> out_way=9, out_evict=0; ptr[5] remains 4; next lookup shows evict_way_buf=4.
- Eviction on set 7 with lk_way=15 -> ptr[7] wraps to 0; a set 7 lookup then drives evict_way_buf=0.
- out_ready held low 5 cycles in RESP -> out_valid and out_* stable for 6 cycles, req_ready=0, no ptr change until handshake.
- clr and req_valid together in IDLE -> req_ready=0, all ptrs 0, request accepted the next cycle; clr pulsed during LKUP -> ignored, ptrs unchanged.
- rst asserted during LKUP -> outputs 0 immediately; after release, IDLE with req_ready=1, no out_valid, ptr[set] unchanged (0).

Source files
------------

// File: rtl/llc_lookup_sched.sv
// Sequencer for the LLC way-lookup datapath: one set lookup in flight, array read,
// way-lookup capture, downstream handshake and per-set round-robin eviction pointer.
module llc_lookup_sched #(
    parameter int SETS     = 256,
    parameter int SET_BITS = 8,
    parameter int WAYS     = 16,
    parameter int WAY_BITS = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    input  logic [SET_BITS-1:0] req_set,
    output logic                req_ready,
    input  logic                clr,
    output logic                rd_en,
    output logic [SET_BITS-1:0] rd_set,
    output logic                lookup_en,
    output logic [WAY_BITS-1:0] evict_way_buf,
    input  logic [WAY_BITS-1:0] lk_way,
    input  logic                lk_evict,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [SET_BITS-1:0] out_set,
    output logic [WAY_BITS-1:0] out_way,
    output logic                out_evict
);

    typedef enum logic [1:0] {IDLE, RD, LKUP, RESP} state_t;

    state_t              state_reg;
    logic [SET_BITS-1:0] set_q_reg;
    logic                rd_en_reg;
    logic                lookup_en_reg;
    logic                out_valid_reg;
    logic [WAY_BITS-1:0] ptr_q [SETS];
    logic [WAY_BITS-1:0] ptr_next;
    logic                accept;
    logic                handshake;
    logic                clr_all;

    assign req_ready = (state_reg == IDLE) && !clr;
    assign accept    = req_valid && req_ready;
    assign handshake = out_valid_reg && out_ready;
    assign clr_all   = (state_reg == IDLE) && clr;
    assign ptr_next  = WAY_BITS'((int'(lk_way) + 1) % WAYS);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg     <= IDLE;
            set_q_reg     <= '0;
            rd_en_reg     <= 1'b0;
            lookup_en_reg <= 1'b0;
            out_valid_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        set_q_reg <= req_set;
                        rd_en_reg <= 1'b1;
                        state_reg <= RD;
                    end
                end
                RD: begin
                    rd_en_reg     <= 1'b0;
                    lookup_en_reg <= 1'b1;
                    state_reg     <= LKUP;
                end
                LKUP: begin
                    lookup_en_reg <= 1'b0;
                    out_valid_reg <= 1'b1;
                    state_reg     <= RESP;
                end
                RESP: begin
                    if (out_ready) begin
                        out_valid_reg <= 1'b0;
                        state_reg     <= IDLE;
                    end
                end
                default: begin
                    rd_en_reg     <= 1'b0;
                    lookup_en_reg <= 1'b0;
                    out_valid_reg <= 1'b0;
                    state_reg     <= IDLE;
                end
            endcase
        end
    end

    // One flop group per set so the whole table can be cleared in a single cycle.
    genvar gi;
    generate
        for (gi = 0; gi < SETS; gi++) begin : g_ptr
            logic [WAY_BITS-1:0] ptr_reg;

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    ptr_reg <= '0;
                end else if (clr_all) begin
                    ptr_reg <= '0;
                end else if (handshake && lk_evict && (set_q_reg == SET_BITS'(gi))) begin
                    ptr_reg <= ptr_next;
                end
            end

            assign ptr_q[gi] = ptr_reg;
        end
    endgenerate

    assign rd_en         = rd_en_reg;
    assign rd_set        = rd_en_reg ? set_q_reg : '0;
    assign lookup_en     = lookup_en_reg;
    assign evict_way_buf = ptr_q[set_q_reg];
    // Lookup-stage result is already registered and held, so RESP forwards it directly.
    assign out_valid     = out_valid_reg;
    assign out_set       = out_valid_reg ? set_q_reg : '0;
    assign out_way       = out_valid_reg ? lk_way : '0;
    assign out_evict     = out_valid_reg && lk_evict;

endmodule
